// File: rtl/reaction_pkg.sv
// Shared types and widths for the reaction timer.
package reaction_pkg;

   localparam int TIME_W   = 14;
   localparam int WINNER_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      RUN,
      DONE,
      FAULT
   } rt_state_t;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: one-cycle pulse every CLK_HZ/TICK_HZ clocks, realigned by restart.
module tick_gen #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int PERIOD = CLK_HZ / TICK_HZ;
   localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   generate
      if (CLK_HZ < TICK_HZ) begin : g_bad_ratio
         $error("tick_gen: CLK_HZ must be >= TICK_HZ");
      end
   endgenerate

   logic [CNT_W-1:0] cnt;

   // Down-counter; terminal count (zero) is the tick, then reload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (restart || cnt == '0)
         cnt <= CNT_W'(PERIOD - 1);
      else
         cnt <= cnt - CNT_W'(1);
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random foreperiod, stimulus, first-stop capture and fault handling.
//
//   state | meaning
//   IDLE  | waiting for a start edge
//   ARM   | one cycle: load random foreperiod, clear results
//   WAIT  | foreperiod countdown; a stop edge here is a false start
//   RUN   | stimulus on, counting reaction ticks
//   DONE  | valid result held until clear
//   FAULT | false start or timeout held until clear
module reaction_timer_core
   import reaction_pkg::*;
#(
   parameter int          CLK_HZ    = 100_000_000,
   parameter int          TICK_HZ   = 1000,
   parameter int          N_PLAYERS = 2,
   parameter int          MIN_DELAY = 1000,
   parameter int          RAND_BITS = 11,
   parameter int          TIMEOUT   = 9999,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 clear,
   input  logic [N_PLAYERS-1:0] stop,
   output logic                 stim,
   output logic [TIME_W-1:0]    time_ticks,
   output logic [WINNER_W-1:0]  winner,
   output logic                 result_valid,
   output logic                 false_start,
   output logic                 timed_out,
   output logic                 busy
);

   localparam int DLY_MAX = MIN_DELAY + (1 << RAND_BITS) - 1;
   localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;

   generate
      if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
         $error("reaction_timer_core: N_PLAYERS must be 1..8");
      end
   endgenerate

   rt_state_t             state, state_nxt;
   logic [DLY_W-1:0]      delay, delay_nxt, delay_load;
   logic [TIME_W-1:0]     time_nxt;
   logic [WINNER_W-1:0]   winner_nxt, stop_win;
   logic                  rv_nxt, fs_nxt, to_nxt, clr_res;
   logic [15:0]           lfsr;
   logic                  start_q, clear_q;
   logic [N_PLAYERS-1:0]  stop_q;
   logic                  start_edge, clear_edge;
   logic [N_PLAYERS-1:0]  stop_edge;
   logic                  tick, restart;

   assign start_edge = start & ~start_q;
   assign clear_edge = clear & ~clear_q;
   assign stop_edge  = stop & ~stop_q;
   assign delay_load = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_BITS-1:0]);

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   // Lowest pressing index wins simultaneous stops.
   always_comb begin
      stop_win = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--)
         if (stop_edge[i]) stop_win = WINNER_W'(i);
   end

   always_comb begin
      state_nxt  = state;
      delay_nxt  = delay;
      time_nxt   = time_ticks;
      winner_nxt = winner;
      rv_nxt     = result_valid;
      fs_nxt     = false_start;
      to_nxt     = timed_out;
      clr_res    = 1'b0;
      restart    = 1'b0;
      case (state)
         IDLE: if (start_edge) state_nxt = ARM;
         ARM: begin
            restart   = 1'b1;
            clr_res   = 1'b1;
            state_nxt = clear_edge ? IDLE : WAIT;
            delay_nxt = delay_load;
         end
         WAIT: begin
            if (clear_edge) begin
               state_nxt = IDLE;
               clr_res   = 1'b1;
            end else if (|stop_edge) begin
               state_nxt  = FAULT;
               fs_nxt     = 1'b1;
               winner_nxt = stop_win;
            end else if (delay == '0) begin
               state_nxt = RUN;
               restart   = 1'b1;
            end else if (tick) begin
               delay_nxt = delay - DLY_W'(1);
            end
         end
         RUN: begin
            // A stop in a tick cycle wins, so the pre-increment count is kept.
            if (clear_edge) begin
               state_nxt = IDLE;
               clr_res   = 1'b1;
            end else if (|stop_edge) begin
               state_nxt  = DONE;
               rv_nxt     = 1'b1;
               winner_nxt = stop_win;
            end else if (tick) begin
               if (time_ticks >= TIME_W'(TIMEOUT - 1)) begin
                  state_nxt = FAULT;
                  to_nxt    = 1'b1;
                  time_nxt  = TIME_W'(TIMEOUT);
               end else begin
                  time_nxt = time_ticks + TIME_W'(1);
               end
            end
         end
         DONE, FAULT: begin
            if (clear_edge) begin
               state_nxt = IDLE;
               clr_res   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (clr_res) begin
         time_nxt   = '0;
         winner_nxt = '0;
         rv_nxt     = 1'b0;
         fs_nxt     = 1'b0;
         to_nxt     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         delay        <= '0;
         time_ticks   <= '0;
         winner       <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         timed_out    <= 1'b0;
         lfsr         <= LFSR_SEED;
         start_q      <= 1'b0;
         clear_q      <= 1'b0;
         stop_q       <= '0;
      end else begin
         state        <= state_nxt;
         delay        <= delay_nxt;
         time_ticks   <= time_nxt;
         winner       <= winner_nxt;
         result_valid <= rv_nxt;
         false_start  <= fs_nxt;
         timed_out    <= to_nxt;
         lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         start_q      <= start;
         clear_q      <= clear;
         stop_q       <= stop;
      end
   end

   // Decoded straight from state so an async reset drops them immediately.
   assign stim = (state == RUN);
   assign busy = (state == ARM) || (state == WAIT) || (state == RUN);

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed self-checking bench for reaction_timer_core (10-cycle tick, 3..6 tick foreperiod).
module tb_reaction_timer_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic [1:0]  stop = 2'b00;
   logic        stim;
   logic [13:0] time_ticks;
   logic [2:0]  winner;
   logic        result_valid, false_start, timed_out, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reaction_timer_core #(
      .CLK_HZ    (100),
      .TICK_HZ   (10),
      .N_PLAYERS (2),
      .MIN_DELAY (3),
      .RAND_BITS (2),
      .TIMEOUT   (20),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .clear        (clear),
      .stop         (stop),
      .stim         (stim),
      .time_ticks   (time_ticks),
      .winner       (winner),
      .result_valid (result_valid),
      .false_start  (false_start),
      .timed_out    (timed_out),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   // Returns the sample index (1 = first negedge after the start edge) at which stim rose.
   task automatic start_and_wait_stim(input string tag);
      int n;
      pulse_start();
      n = 1;
      while (stim !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_stim_rose"}, stim, 1);
      check({tag, "_stim_window"}, (n >= 33 && n <= 63 && (n - 3) % 10 == 0), 1);
      check({tag, "_run_time0"}, time_ticks, 0);
   endtask

   initial begin
      int m;

      // Reset state
      cycles(3);
      check("rst_stim", stim, 0);
      check("rst_busy", busy, 0);
      check("rst_time", time_ticks, 0);
      check("rst_winner", winner, 0);
      check("rst_flags", {result_valid, false_start, timed_out}, 0);
      reset = 1'b0;
      cycles(2);

      // Edges other than start are ignored in IDLE
      stop = 2'b11;
      cycles(2);
      stop = 2'b00;
      check("idle_ignore_stop", {busy, false_start, result_valid}, 0);

      // Timeout: saturate at 20 after exactly 200 cycles of RUN
      start_and_wait_stim("to");
      check("to_busy", busy, 1);
      m = 0;
      while (timed_out !== 1'b1 && m < 400) begin
         @(negedge clk);
         m++;
      end
      check("to_flag", timed_out, 1);
      check("to_latency", m, 200);
      check("to_time", time_ticks, 20);
      check("to_stim", stim, 0);
      check("to_busy_low", busy, 0);
      cycles(25);
      pulse_start();
      cycles(2);
      check("to_hold_time", time_ticks, 20);
      check("to_hold_flag", {timed_out, busy}, 2'b10);
      pulse_clear();
      check("to_clear", {timed_out, time_ticks}, 0);

      // Stop[1] 55 cycles into RUN -> 5 ticks
      start_and_wait_stim("s1");
      cycles(55);
      stop = 2'b10;
      @(negedge clk);
      check("s1_valid", result_valid, 1);
      check("s1_winner", winner, 1);
      check("s1_time", time_ticks, 5);
      check("s1_stim", stim, 0);
      check("s1_busy", busy, 0);
      stop = 2'b00;
      cycles(30);
      pulse_start();
      cycles(2);
      check("s1_frozen", time_ticks, 5);
      check("s1_hold_valid", {result_valid, busy}, 2'b10);
      pulse_clear();
      check("s1_clear_valid", result_valid, 0);
      check("s1_clear_time", time_ticks, 0);

      // Simultaneous stops resolve to player 0
      start_and_wait_stim("both");
      cycles(12);
      stop = 2'b11;
      @(negedge clk);
      stop = 2'b00;
      check("both_winner", winner, 0);
      check("both_valid", result_valid, 1);
      check("both_time", time_ticks, 1);
      pulse_clear();

      // Stop in the same cycle as a tick keeps the pre-increment count
      start_and_wait_stim("tk");
      cycles(9);
      stop = 2'b01;
      @(negedge clk);
      stop = 2'b00;
      check("tk_time", time_ticks, 0);
      check("tk_valid_winner", {result_valid, winner}, 4'b1000);
      pulse_clear();

      // False start during WAIT
      pulse_start();
      cycles(5);
      check("fs_wait_busy", {busy, stim}, 2'b10);
      stop = 2'b10;
      @(negedge clk);
      stop = 2'b00;
      check("fs_flag", false_start, 1);
      check("fs_winner", winner, 1);
      check("fs_stim", stim, 0);
      check("fs_valid_busy", {result_valid, busy}, 0);
      cycles(80);
      check("fs_stim_never", stim, 0);
      pulse_clear();
      check("fs_clear", false_start, 0);

      // Clear aborts during WAIT
      pulse_start();
      cycles(4);
      pulse_clear();
      check("abort_busy", busy, 0);
      cycles(80);
      check("abort_no_stim", stim, 0);

      // Async reset mid-RUN
      start_and_wait_stim("ar");
      cycles(25);
      #2 reset = 1'b1;
      #1;
      check("ar_stim", stim, 0);
      check("ar_busy", busy, 0);
      check("ar_time", time_ticks, 0);
      check("ar_flags", {result_valid, false_start, timed_out, winner}, 0);
      @(negedge clk);
      reset = 1'b0;
      cycles(2);
      check("ar_idle", {busy, stim}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
